mem_port_sched: RTL and testbench
=================================

# mem_port_sched

Sequencer and arbiter that lets the instruction-fetch path and the load/store path share one byte-wide, single-port memory array. It accepts word fetches and sized data loads and stores (byte, half, word, matching the func3 encoding the datapath already produces), serialises each into 1, 2 or 4 byte-cycles on the array, and returns assembled, sign- or zero-extended read data. It sits between the core's fetch/memory stages and a 256-byte storage array with asynchronous read and synchronous write.

## Interface
Parameters:
- ADDR_W, 8, byte address width; array depth is 2^ADDR_W bytes.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset: 0 resets, 1 runs.
- if_req  in  1  fetch request; held high until if_done.
- if_addr  in  ADDR_W  fetch byte address; stable while if_req is high.
- if_done  out  1  one-cycle pulse: fetch complete.
- if_rdata  out  32  fetched word, little-endian; valid while if_done is high.
- d_req  in  1  data request; held high until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_func3  in  3  size/extension code: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
- d_wdata  in  32  store data; the low bytes are used.
- d_done  out  1  one-cycle pulse: data access complete.
- d_rdata  out  32  extended load data; valid while d_done is high; 0 for stores.
- mem_addr  out  ADDR_W  array byte address.
- mem_we  out  1  array write strobe.
- mem_wdata  out  8  array write byte.
- mem_rdata  in  8  array read byte (combinational from mem_addr).
- busy  out  1  high in XFER and DONE.

## Operation
- FSM states: IDLE, XFER, DONE.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the requester not granted last; the last-grant flag resets to "data", so fetch wins the first tie.
  - On a grant, latch addr, func3, we and wdata; clear cnt and the read buffer; go to XFER.
- Byte count n:
  - Fetch: n = 4.
  - Data: n = 1 for func3 000/100, 2 for 001/101, 4 for 010.
  - Illegal func3 (011, 110, 111): n = 0. Go directly to DONE with rdata 0 and no array write.
- XFER, per cycle, with cnt = 0 .. n-1:
  - mem_addr = base + cnt, modulo 2^ADDR_W (wraps 0xFF -> 0x00).
  - Read: byte lane cnt of the buffer <= mem_rdata.
  - Store: mem_we = 1 and mem_wdata = wdata[8*cnt+7 : 8*cnt].
  - After cnt reaches n-1, go to DONE.
- DONE: pulse the granted done for one cycle, then return to IDLE.
  - rdata for func3 000: sign-extend byte 0. For 001: sign-extend bytes 1:0. For 100/101: zero-extend. For 010 and fetch: all 4 bytes.
  - Store: d_rdata = 0.
- mem_we is never high outside XFER. mem_addr = 0 in IDLE.
- A request still high in the IDLE cycle after done counts as a new request.
- Request inputs are ignored while busy.
- rst low at any time, including mid-transfer: return immediately to IDLE, drive all outputs to 0, clear cnt, the buffer and the last-grant flag (to "data"). No done is issued. Bytes already written stay written.

## Timing
- Reset values: if_done, d_done, if_rdata, d_rdata, mem_addr, mem_we, mem_wdata and busy are all 0.
- If a request is sampled at rising edge t, XFER runs for cycles t+1 .. t+n and done is high in cycle t+n+1.
  - Fetch and lw/sw: done 5 cycles after the grant edge.
  - Half-word access: 3 cycles. Byte access: 2 cycles. Illegal func3: 1 cycle.
- Back-to-back throughput: one access per n+2 cycles.
- done and rdata are registered (Moore outputs). mem_addr, mem_we and mem_wdata are decoded from state and cnt.

## Test plan
- Fetch only: array[0x10..0x13] = 93,00,41,00; if_req with if_addr = 0x10 -> if_done pulses 5 cycles after the grant, if_rdata = 0x00410093, d_done stays 0.
- Signed and unsigned byte: array[0x11] = 0xAA; lb at 0x11 -> d_rdata = 0xFFFFFFAA after 2 cycles; lbu -> 0x000000AA.
- Wrapping halfword: sh with d_wdata = 0x1234 at address 0xFF -> array[0xFF] = 0x34, array[0x00] = 0x12; a following lh returns 0x00001234.
- Simultaneous requests: if_req and d_req rise in the same cycle and stay high -> fetch is served first, then data, then fetch; no requester is granted twice in a row while the other waits.
- Reset mid-store: sw of 0xDEADBEEF to 0x20; rst driven low after 2 XFER cycles -> array[0x20] = 0xEF, array[0x21] = 0xBE, array[0x22..0x23] unchanged, no d_done, all outputs 0.
- Illegal func3 011 load -> d_done one cycle after the grant, d_rdata = 0, mem_we never asserted.

Source files
------------

// File: rtl/mem_port_sched.sv
// Shares one byte-wide single-port array between instruction fetch and load/store.
// Each access is serialised into 1, 2 or 4 byte cycles; done and read data are registered.
module mem_port_sched #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [2:0]        d_func3,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  localparam logic [2:0] F3_WORD = 3'b010;

  function automatic logic [2:0] nbytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: nbytes = 3'd1;
      3'b001, 3'b101: nbytes = 3'd2;
      3'b010:         nbytes = 3'd4;
      default:        nbytes = 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'b000:  extend = {{24{w[7]}}, w[7:0]};
      3'b001:  extend = {{16{w[15]}}, w[15:0]};
      3'b100:  extend = {24'd0, w[7:0]};
      3'b101:  extend = {16'd0, w[15:0]};
      3'b010:  extend = w;
      default: extend = 32'd0;
    endcase
  endfunction

  state_t            state, state_n;
  logic              last_d;   // last grant went to data; reset value makes fetch win the first tie
  logic              gnt_d;
  logic              we;
  logic [ADDR_W-1:0] base;
  logic [2:0]        f3;
  logic [31:0]       wdata;
  logic [31:0]       rbuf;
  logic [1:0]        cnt;

  logic              any_req, pick_d, xfer_last;
  logic [2:0]        req_f3, req_n;
  logic [31:0]       merged;

  assign any_req   = if_req | d_req;
  assign pick_d    = d_req & (~if_req | ~last_d);
  assign req_f3    = pick_d ? d_func3 : F3_WORD;
  assign req_n     = nbytes(req_f3);
  assign xfer_last = ({1'b0, cnt} == nbytes(f3) - 3'd1);
  // buffer with the byte currently on the array merged in, so the final lane is not lost
  assign merged    = rbuf | ({24'd0, mem_rdata} << {cnt, 3'b000});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_req) state_n = (req_n == 3'd0) ? DONE : XFER;
      XFER:    if (xfer_last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d   <= 1'b1;
      gnt_d    <= 1'b0;
      we       <= 1'b0;
      base     <= '0;
      f3       <= 3'd0;
      wdata    <= 32'd0;
      rbuf     <= 32'd0;
      cnt      <= 2'd0;
      if_done  <= 1'b0;
      d_done   <= 1'b0;
      if_rdata <= 32'd0;
      d_rdata  <= 32'd0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          gnt_d  <= pick_d;
          last_d <= pick_d;
          base   <= pick_d ? d_addr : if_addr;
          f3     <= req_f3;
          we     <= pick_d & d_we;
          wdata  <= d_wdata;
          cnt    <= 2'd0;
          rbuf   <= 32'd0;
          // only a data request can carry an illegal size
          if (req_n == 3'd0) begin
            d_done  <= 1'b1;
            d_rdata <= 32'd0;
          end
        end
        XFER: begin
          rbuf <= merged;
          cnt  <= cnt + 2'd1;
          if (xfer_last) begin
            if (gnt_d) begin
              d_done  <= 1'b1;
              d_rdata <= we ? 32'd0 : extend(f3, merged);
            end else begin
              if_done  <= 1'b1;
              if_rdata <= merged;
            end
          end
        end
        DONE: begin
          if_done <= 1'b0;
          d_done  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = 8'd0;
    if (state == XFER) begin
      mem_addr  = base + ADDR_W'(cnt);
      mem_we    = we;
      mem_wdata = we ? wdata[{cnt, 3'b000} +: 8] : 8'd0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_port_sched.sv
// Bench for mem_port_sched: byte array model plus a shadow-memory reference that
// predicts read data, latency and write activity for directed and random accesses.
module tb_mem_port_sched;
  logic        clk;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [7:0]  if_addr, d_addr;
  logic [2:0]  d_func3;
  logic [31:0] d_wdata;
  logic        if_done, d_done, mem_we, busy;
  logic [31:0] if_rdata, d_rdata;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;

  logic [7:0]  mem     [256];
  logic [7:0]  ref_mem [256];
  logic        bd_en;
  logic [7:0]  bd_addr, bd_data;

  int n_vec = 0;
  int n_err = 0;

  mem_port_sched #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_func3(d_func3), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we)     mem[mem_addr] <= mem_wdata;
    else if (bd_en) mem[bd_addr]  <= bd_data;
  end
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nsz(input bit isf, input logic [2:0] f3);
    if (isf) return 4;
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input bit isf, input logic [7:0] a, input logic [2:0] f3);
    longint v;
    int n;
    v = 0;
    n = nsz(isf, f3);
    for (int i = 0; i < n; i++) v += longint'(ref_mem[(int'(a) + i) % 256]) << (8 * i);
    if (!isf && f3 == 3'b000 && v >= 128)   v -= 256;
    if (!isf && f3 == 3'b001 && v >= 32768) v -= 65536;
    return v[31:0];
  endfunction

  task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
    bd_addr = a; bd_data = d; bd_en = 1'b1;
    @(negedge clk);
    bd_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_op(input string tag, input bit isf, input logic [7:0] a,
                       input logic [2:0] f3, input bit w, input logic [31:0] wd);
    int n, cyc, wes;
    bit got, oth, bsy;
    logic [31:0] exp_rd, obs_rd;
    n = nsz(isf, f3);
    exp_rd = (isf || !w) ? ref_load(isf, a, f3) : 32'd0;
    if (isf) begin
      if_req = 1'b1; if_addr = a;
    end else begin
      d_req = 1'b1; d_we = w; d_addr = a; d_func3 = f3; d_wdata = wd;
    end
    cyc = 0; wes = 0; got = 0; oth = 0; bsy = 0;
    while (!got && cyc < 20) begin
      @(posedge clk); @(negedge clk); cyc++;
      if (cyc == 1) bsy = busy;
      if (mem_we) wes++;
      if (isf ? d_done : if_done) oth = 1;
      if (isf ? if_done : d_done) got = 1;
    end
    obs_rd = isf ? if_rdata : d_rdata;
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk({tag, "_done"},  32'(got), 32'd1);
    chk({tag, "_lat"},   cyc, n + 1);
    chk({tag, "_rdata"}, obs_rd, exp_rd);
    chk({tag, "_other"}, 32'(oth), 32'd0);
    chk({tag, "_we"},    wes, (!isf && w) ? n : 0);
    chk({tag, "_busy"},  32'(bsy), 32'd1);
    if (!isf && w)
      for (int i = 0; i < n; i++) ref_mem[(int'(a) + i) % 256] = 8'(wd >> (8 * i));
  endtask

  initial begin
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = 8'd0; d_addr = 8'd0; d_func3 = 3'd0; d_wdata = 32'd0;
    bd_en = 1'b0; bd_addr = 8'd0; bd_data = 8'd0;
    @(negedge clk);
    chk("rst_ctl", 32'({if_done, d_done, busy, mem_we, mem_wdata, mem_addr}), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    for (int i = 0; i < 256; i++) bd_write(8'(i), 8'($urandom));
    rst = 1'b1;
    @(negedge clk);

    // fetch of a known word
    bd_write(8'h10, 8'h93); bd_write(8'h11, 8'h00);
    bd_write(8'h12, 8'h41); bd_write(8'h13, 8'h00);
    do_op("fetch", 1'b1, 8'h10, 3'b010, 1'b0, 32'd0);

    // signed and unsigned byte
    bd_write(8'h11, 8'hAA);
    do_op("lb",  1'b0, 8'h11, 3'b000, 1'b0, 32'd0);
    do_op("lbu", 1'b0, 8'h11, 3'b100, 1'b0, 32'd0);

    // halfword wrapping past the top of the array
    do_op("sh_wrap", 1'b0, 8'hFF, 3'b001, 1'b1, 32'h0000_1234);
    chk("sh_wrap_mFF", 32'(mem[8'hFF]), 32'h34);
    chk("sh_wrap_m00", 32'(mem[8'h00]), 32'h12);
    do_op("lh_wrap", 1'b0, 8'hFF, 3'b001, 1'b0, 32'd0);

    // illegal size
    do_op("ill011", 1'b0, 8'h30, 3'b011, 1'b0, 32'd0);
    do_op("ill110st", 1'b0, 8'h30, 3'b110, 1'b1, 32'hFFFF_FFFF);

    // tie arbitration right after reset: fetch first, then strict alternation
    rst = 1'b0; @(negedge clk); @(negedge clk); rst = 1'b1;
    if_addr = 8'h40; d_addr = 8'h80; d_we = 1'b0; d_func3 = 3'b010;
    if_req = 1'b1; d_req = 1'b1;
    begin
      int ev, cyc, last_cyc;
      ev = 0; cyc = 0; last_cyc = 0;
      while (ev < 4 && cyc < 60) begin
        @(posedge clk); @(negedge clk); cyc++;
        if (if_done || d_done) begin
          chk($sformatf("arb%0d_fetch", ev), 32'(if_done), 32'(ev % 2 == 0));
          chk($sformatf("arb%0d_data", ev),  32'(d_done),  32'(ev % 2 == 1));
          if (ev == 0) chk("arb_first_lat", cyc, 5);
          else         chk($sformatf("arb%0d_gap", ev), cyc - last_cyc, 6);
          if (ev == 0) chk("arb_if_rdata", if_rdata, ref_load(1'b1, 8'h40, 3'b010));
          if (ev == 1) chk("arb_d_rdata", d_rdata, ref_load(1'b0, 8'h80, 3'b010));
          last_cyc = cyc;
          ev++;
        end
      end
      if_req = 1'b0; d_req = 1'b0;
      chk("arb_events", ev, 4);
      @(negedge clk); @(negedge clk);
    end

    // reset in the middle of a word store
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_func3 = 3'b010; d_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_ctl", 32'({if_done, d_done, busy, mem_we, mem_wdata, mem_addr}), 32'd0);
    chk("mid_rst_if_rdata", if_rdata, 32'd0);
    chk("mid_rst_d_rdata", d_rdata, 32'd0);
    d_req = 1'b0;
    begin
      bit seen;
      seen = 0;
      repeat (3) begin
        @(negedge clk);
        if (d_done || if_done) seen = 1;
      end
      chk("mid_rst_nodone", 32'(seen), 32'd0);
    end
    rst = 1'b1;
    ref_mem[8'h20] = 8'hEF;
    ref_mem[8'h21] = 8'hBE;
    for (int i = 0; i < 4; i++)
      chk($sformatf("mid_rst_m%0d", i), 32'(mem[8'h20 + i]), 32'(ref_mem[8'h20 + i]));
    @(negedge clk);

    // random traffic against the shadow memory
    for (int k = 0; k < 80; k++) begin
      bit isf, w;
      logic [7:0] a;
      logic [2:0] f3;
      int sel;
      isf = ($urandom_range(0, 3) == 0);
      a   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(252, 255)) : 8'($urandom);
      w   = ($urandom_range(0, 1) == 1);
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    f3 = 3'b000;
        2, 3:    f3 = 3'b001;
        4, 5:    f3 = 3'b010;
        6:       f3 = w ? 3'b000 : 3'b100;
        7:       f3 = w ? 3'b001 : 3'b101;
        8:       f3 = 3'b011;
        default: f3 = ($urandom_range(0, 1) == 1) ? 3'b110 : 3'b111;
      endcase
      do_op($sformatf("rnd%0d", k), isf, a, f3, w, $urandom);
    end

    for (int i = 0; i < 256; i++)
      chk($sformatf("final_m%0d", i), 32'(mem[i]), 32'(ref_mem[i]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
